// File: rtl/alu_pkg.sv
// alu_pkg: opcode enum and shared constants for processor_exec_unit
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_OR  = 4'b0010,
    OP_AND = 4'b0011,
    OP_DIV = 4'b0100,
    OP_MUL = 4'b0101
  } alu_op_e;
  localparam int          XLEN   = 32;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/cla_adder32.sv
// cla_adder32: 32-bit adder built from 4-bit carry-lookahead groups
module cla_adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] s_o,
  output logic        c_o
);
  logic [31:0] g, p;
  logic [32:0] c;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  // Each group resolves its carries directly from its own carry-in
  always_comb begin
    c = '0;
    c[0] = c_i;
    for (int k = 0; k < 32; k += 4) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
             | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
             | (p[k+3] & p[k+2] & p[k+1] & g[k]) | ((&p[k+3 -: 4]) & c[k]);
    end
  end
  assign s_o = p ^ c[31:0];
  assign c_o = c[32];
endmodule

// File: rtl/processor_exec_unit.sv
// processor_exec_unit: ALU with registered results plus PC register; ALU_DIV_EN enables the divider
module processor_exec_unit
  import alu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic [31:0] iImm,
  input  logic        iBSel,
  input  logic [3:0]  iCtrl,
  input  logic        iZEn,
  output logic [31:0] oC0,
  output logic [31:0] oC1,
  output logic        oZero,
  input  logic        iPcEn,
  input  logic        iIncSel,
  input  logic [18:0] iOffset,
  input  logic        iPcSel,
  input  logic [31:0] iPcLoad,
  output logic [31:0] oPc
);
  logic [31:0] b_op, sum, c0_d, c1_d, c0_q, c1_q, inc, pc_sum, pc_d, pc_q;
  logic        sub, zero_q, alu_co_unused, pc_co_unused;
  logic signed [63:0] prod;
  assign b_op = iBSel ? iImm : iB;
  assign sub  = iCtrl == OP_SUB;
  cla_adder32 u_alu_add (
    .a_i(iA), .b_i(sub ? ~b_op : b_op), .c_i(sub), .s_o(sum), .c_o(alu_co_unused)
  );
  assign prod = $signed(iA) * $signed(b_op);
`ifdef ALU_DIV_EN
  logic signed [31:0] sq, sr;
  logic [31:0] quo, rem;
  logic        ovf, dz;
  assign sq  = $signed(iA) / $signed(b_op);
  assign sr  = $signed(iA) % $signed(b_op);
  assign dz  = b_op == '0;
  assign ovf = iA == 32'h8000_0000 && b_op == '1;
  assign quo = dz ? '1 : ovf ? 32'h8000_0000 : sq;
  assign rem = dz ? iA : ovf ? '0 : sr;
`endif
  // Opcode decode into primary/secondary results
  always_comb begin
    c0_d = '0;
    c1_d = '0;
    case (iCtrl)
      OP_ADD, OP_SUB: c0_d = sum;
      OP_OR:          c0_d = iA | b_op;
      OP_AND:         c0_d = iA & b_op;
      OP_MUL:         {c1_d, c0_d} = prod;
`ifdef ALU_DIV_EN
      OP_DIV: begin
        c0_d = quo;
        c1_d = rem;
      end
`endif
      default: ;
    endcase
  end
  assign inc  = iIncSel ? {{13{iOffset[18]}}, iOffset} : PC_INC;
  cla_adder32 u_pc_add (
    .a_i(pc_q), .b_i(inc), .c_i(1'b0), .s_o(pc_sum), .c_o(pc_co_unused)
  );
  assign pc_d = iPcSel ? pc_sum : iPcLoad;
  // Result and PC registers; reset wins over both load enables
  always_ff @(posedge iClk) begin
    if (!nRst) begin
      c0_q   <= '0;
      c1_q   <= '0;
      zero_q <= 1'b1;
      pc_q   <= PC_RESET;
    end else begin
      if (iZEn) begin
        c0_q   <= c0_d;
        c1_q   <= c1_d;
        zero_q <= c0_d == '0;
      end
      if (iPcEn) pc_q <= pc_d;
    end
  end
  assign oC0   = c0_q;
  assign oC1   = c1_q;
  assign oZero = zero_q;
  assign oPc   = pc_q;
endmodule

// File: tb/tb_processor_exec_unit.sv
// tb_processor_exec_unit: scoreboard-driven self-checking bench for processor_exec_unit
module tb_processor_exec_unit;
  logic        iClk = 0, nRst = 0, iBSel = 0, iZEn = 0, iPcEn = 0, iIncSel = 0, iPcSel = 0;
  logic [31:0] iA = 0, iB = 0, iImm = 0, iPcLoad = 0;
  logic [3:0]  iCtrl = 0;
  logic [18:0] iOffset = 0;
  logic [31:0] oC0, oC1, oPc;
  logic        oZero;
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] c0, c1;
    logic        z;
    string       nm;
  } exp_t;
  exp_t sb[$];
  logic [31:0] last_c0, last_c1;
  logic        last_z;

  processor_exec_unit #(.PC_RESET(32'h0)) dut (
    .iClk(iClk), .nRst(nRst), .iA(iA), .iB(iB), .iImm(iImm), .iBSel(iBSel),
    .iCtrl(iCtrl), .iZEn(iZEn), .oC0(oC0), .oC1(oC1), .oZero(oZero),
    .iPcEn(iPcEn), .iIncSel(iIncSel), .iOffset(iOffset), .iPcSel(iPcSel),
    .iPcLoad(iPcLoad), .oPc(oPc)
  );

  always #5 iClk = ~iClk;

  function automatic logic [63:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] p;
    case (op)
      4'b0000: return {32'h0, a + b};
      4'b0001: return {32'h0, a - b};
      4'b0010: return {32'h0, a | b};
      4'b0011: return {32'h0, a & b};
      4'b0101: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_pc(input logic [31:0] want, input string nm);
    checks++;
    if (oPc !== want) begin
      errors++;
      $display("FAIL %s oPc got %h want %h", nm, oPc, want);
    end
  endtask

  task automatic alu_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic bsel,
                          input logic [31:0] e0, input logic [31:0] e1, input string nm);
    exp_t e;
    iCtrl = op; iA = a; iB = b; iImm = imm; iBSel = bsel; iZEn = 1;
    sb.push_back('{e0, e1, e0 == 32'h0, nm});
    step();
    iZEn = 0;
    e = sb.pop_front();
    checks += 3;
    if (oC0 !== e.c0) begin errors++; $display("FAIL %s oC0 got %h want %h", e.nm, oC0, e.c0); end
    if (oC1 !== e.c1) begin errors++; $display("FAIL %s oC1 got %h want %h", e.nm, oC1, e.c1); end
    if (oZero !== e.z) begin errors++; $display("FAIL %s oZero got %b want %b", e.nm, oZero, e.z); end
    last_c0 = e.c0; last_c1 = e.c1; last_z = e.z;
  endtask

  task automatic chk_alu_reset(input string nm);
    checks += 3;
    if (oC0 !== 32'h0) begin errors++; $display("FAIL %s oC0 got %h want 0", nm, oC0); end
    if (oC1 !== 32'h0) begin errors++; $display("FAIL %s oC1 got %h want 0", nm, oC1); end
    if (oZero !== 1'b1) begin errors++; $display("FAIL %s oZero got %b want 1", nm, oZero); end
  endtask

  task automatic test_reset();
    nRst = 0; iZEn = 1; iPcEn = 1; iPcSel = 0; iPcLoad = 32'h1234; iA = 32'h55; iCtrl = 4'b0000;
    step();
    chk_alu_reset("reset");
    chk_pc(32'h0, "reset_pc");
    nRst = 1; iZEn = 0; iPcSel = 1; iIncSel = 0;
    repeat (3) step();
    chk_pc(32'd12, "pc_inc3");
    iPcEn = 0;
  endtask

  task automatic test_add_sub();
    alu_step(4'b0001, 32'd5, 32'd5, 32'h0, 0, 32'h0, 32'h0, "sub_zero");
    alu_step(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0, 0, 32'h0, 32'h0, "add_wrap");
    alu_step(4'b0001, 32'd3, 32'd5, 32'h0, 0, 32'hFFFF_FFFE, 32'h0, "sub_neg");
    alu_step(4'b0000, 32'h1234_5678, 32'h1111_1111, 32'h0, 0, 32'h2345_6789, 32'h0, "add_plain");
  endtask

  task automatic test_imm_mux();
    alu_step(4'b0010, 32'hF0, 32'hFFFF_0000, 32'h0F, 1, 32'hFF, 32'h0, "imm_or");
    alu_step(4'b0011, 32'hF0, 32'hFFFF_FFFF, 32'h0F, 1, 32'h0, 32'h0, "imm_and");
    alu_step(4'b0011, 32'hF0, 32'hFFFF_FFFF, 32'h0F, 0, 32'hF0, 32'h0, "reg_and");
  endtask

  task automatic test_mul();
    alu_step(4'b0101, 32'hDEAD_BEEF, 32'd2, 32'h0, 0, 32'hBD5B_7DDE, 32'hFFFF_FFFF, "mul_dead");
    alu_step(4'b0101, -32'sd3, 32'd7, 32'h0, 0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, "mul_neg");
    alu_step(4'b0101, 32'h8000_0000, 32'h8000_0000, 32'h0, 0, 32'h0, 32'h4000_0000, "mul_min");
  endtask

  task automatic test_div();
`ifdef ALU_DIV_EN
    alu_step(4'b0100, -32'sd7, 32'd2, 32'h0, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_neg");
    alu_step(4'b0100, 32'h1234_5678, 32'd0, 32'h0, 0, 32'hFFFF_FFFF, 32'h1234_5678, "div_zero");
    alu_step(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 32'h8000_0000, 32'h0, "div_ovf");
    alu_step(4'b0100, 32'd100, 32'd7, 32'h0, 0, 32'd14, 32'd2, "div_pos");
`else
    alu_step(4'b0100, -32'sd7, 32'd2, 32'h0, 0, 32'h0, 32'h0, "div_off");
    alu_step(4'b0100, 32'h1234_5678, 32'd0, 32'h0, 0, 32'h0, 32'h0, "div_off_zero");
`endif
    alu_step(4'b1111, 32'hFFFF_FFFF, 32'd9, 32'h0, 0, 32'h0, 32'h0, "op_undef");
  endtask

  task automatic test_hold();
    alu_step(4'b0000, 32'd10, 32'd20, 32'h0, 0, 32'd30, 32'h0, "pre_hold");
    iA = 32'hAAAA; iB = 32'h5555; iCtrl = 4'b0101; iZEn = 0;
    step();
    checks += 3;
    if (oC0 !== last_c0) begin errors++; $display("FAIL hold oC0 got %h want %h", oC0, last_c0); end
    if (oC1 !== last_c1) begin errors++; $display("FAIL hold oC1 got %h want %h", oC1, last_c1); end
    if (oZero !== last_z) begin errors++; $display("FAIL hold oZero got %b want %b", oZero, last_z); end
  endtask

  task automatic test_pc();
    iPcEn = 1; iPcSel = 0; iPcLoad = 32'h10;
    step(); chk_pc(32'h10, "pc_load10");
    iPcSel = 1; iIncSel = 1; iOffset = 19'h7FFFC;
    step(); chk_pc(32'h0C, "pc_branch_back");
    iOffset = 19'h00100;
    step(); chk_pc(32'h10C, "pc_branch_fwd");
    iPcSel = 0; iPcLoad = 32'hFFFF_FFFC;
    step(); chk_pc(32'hFFFF_FFFC, "pc_load_top");
    iPcSel = 1; iIncSel = 0;
    step(); chk_pc(32'h0, "pc_wrap");
    iPcSel = 0; iPcLoad = 32'h100;
    step(); chk_pc(32'h100, "pc_load100");
    iPcEn = 0; iPcLoad = 32'h200;
    repeat (2) step();
    chk_pc(32'h100, "pc_hold");
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    logic [3:0]  op;
    logic [31:0] a, b;
    iPcEn = 1; iPcSel = 1; iIncSel = 0;
    for (int i = 0; i < 20; i++) begin
      op = i % 6 == 4 ? 4'b0101 : 4'(i % 6);
      a = $urandom; b = $urandom;
      if (i % 5 == 0) b = a;
      r = model(op, a, b);
      alu_step(op, a, b, 32'h0, 0, r[31:0], r[63:32], "rand_op");
      chk_pc(32'h100 + 32'd4 * 32'(i + 1), "pc_concurrent");
    end
    iPcEn = 0;
  endtask

  task automatic test_reset_mid();
    iA = 32'd7; iB = 32'd9; iCtrl = 4'b0000; iBSel = 0; iZEn = 1; iPcEn = 1; iPcSel = 0; iPcLoad = 32'h44;
    nRst = 0;
    step();
    chk_alu_reset("reset_mid");
    chk_pc(32'h0, "reset_mid_pc");
    nRst = 1; iZEn = 0; iPcEn = 0;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_imm_mux();
    test_mul();
    test_div();
    test_hold();
    test_pc();
    test_back_to_back();
    test_reset_mid();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/processor_exec_unit.md
PROCESSOR_EXEC_UNIT -- requirements
Module: processor_exec_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, program-counter value loaded on reset.
REQ-002 SHALL have port iClk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port nRst, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port iA, input, 32, ALU operand A (RA register value).
REQ-005 SHALL have port iB, input, 32, ALU operand B candidate (RB register value).
REQ-006 SHALL have port iImm, input, 32, immediate operand B candidate.
REQ-007 SHALL have port iBSel, input, 1, operand-B select: 0=iB, 1=iImm.
REQ-008 SHALL have port iCtrl, input, 4, ALU operation code.
REQ-009 SHALL have port iZEn, input, 1, load enable for result registers oC0/oC1/oZero.
REQ-010 SHALL have ports oC0 and oC1, output, 32 each, registered low/primary and high/secondary results.
REQ-011 SHALL have port oZero, output, 1, registered flag, 1 when the primary result is zero.
REQ-012 SHALL have ports iPcEn (1), iIncSel (1), iOffset (19), iPcSel (1), iPcLoad (32) as inputs.
REQ-013 SHALL have port oPc, output, 32, program-counter register.

Function
REQ-014 Operand B SHALL be iImm when iBSel=1, else iB (2:1 mux, combinational).
REQ-015 Opcodes: 0000 add, 0001 sub (A-B), 0010 OR, 0011 AND, 0100 divide, 0101 multiply.
REQ-016 Add/sub/OR/AND: C0=result mod 2^32, C1=0; carry/overflow discarded, wrap-around silent.
REQ-017 Multiply: signed 32x32; C0=product[31:0], C1=product[63:32].
REQ-018 Divide: signed, truncating toward zero; C0=quotient, C1=remainder (sign of A).
REQ-019 Divide by zero: C0=32'hFFFF_FFFF, C1=A; no other side effect.
REQ-020 Divide 0x8000_0000 by -1: C0=0x8000_0000, C1=0.
REQ-021 Opcodes 0110-1111: C0=0, C1=0.
REQ-022 On rising edge with iZEn=1: oC0, oC1 and oZero (= C0==0) load; latency exactly 1 cycle; iZEn=0 holds.
REQ-023 PC next value: iPcSel=0 -> iPcLoad; iPcSel=1 -> oPc + increment.
REQ-024 Increment: iIncSel=0 -> 32'd4; iIncSel=1 -> iOffset sign-extended from bit 18.
REQ-025 PC add SHALL wrap modulo 2^32; oPc loads only when iPcEn=1, else holds.
REQ-026 ALU path and PC path are independent; simultaneous iZEn and iPcEn both take effect same edge.

Reset
REQ-027 On a rising edge with nRst=0: oC0=0, oC1=0, oZero=1, oPc=PC_RESET.
REQ-028 Reset SHALL override iZEn and iPcEn on the same edge; reset mid-operation discards pending results.
REQ-029 No asynchronous reset path; nRst sampled only at iClk rising edge.

Configuration
REQ-030 Macro ALU_DIV_EN defined: divide implemented per REQ-018..020.
REQ-031 ALU_DIV_EN undefined: no divider logic; opcode 0100 behaves as REQ-021 (C0=C1=0, oZero=1 when loaded).

Structure
REQ-032 Shared package alu_pkg SHALL hold the 4-bit opcode enum, opcode constants and PC_INC constant (4).
REQ-033 One sub-module cla_adder32 (32-bit carry-lookahead adder, carry-in, carry-out) SHALL serve add, sub (A+~B+1) and PC increment (two instances).
REQ-034 Multiplier and divider SHALL be combinational, single-cycle, inside processor_exec_unit.

Verification
REQ-035 Reset: nRst=0 one edge -> oC0=0, oC1=0, oZero=1, oPc=0; then iPcEn=1, iPcSel=1, iIncSel=0 for 3 edges -> oPc=12.
REQ-036 Add/sub: iA=5, iB=5, iCtrl=0001, iZEn=1 -> next cycle oC0=0, oZero=1; iCtrl=0000, iA=0xFFFF_FFFF, iB=1 -> oC0=0, oZero=1, oC1=0.
REQ-037 Immediate mux: iBSel=1, iImm=0x0F, iA=0xF0, iCtrl=0010 -> oC0=0xFF; iCtrl=0011 -> oC0=0.
REQ-038 Multiply: iA=0xDEADBEEF, iB=2 -> oC0=0xBD5B7DDE, oC1=0xFFFFFFFF; iA=-3, iB=7 -> oC0=0xFFFFFFEB, oC1=0xFFFFFFFF.
REQ-039 Divide (ALU_DIV_EN): iA=-7, iB=2 -> oC0=-3, oC1=-1; iB=0 -> oC0=0xFFFFFFFF, oC1=iA; without macro -> 0,0.
REQ-040 PC branch/wrap: oPc=0x10, iIncSel=1, iOffset=19'h7FFFC -> oPc=0x0C; oPc=0xFFFFFFFC, +4 -> 0; iPcSel=0, iPcLoad=0x100 -> 0x100; iPcEn=0 holds.
